// File: rtl/nurn_integrate_fire_if.sv
// Scheduler handshake plus status-memory ports A (read), B (write) and E (weight read)
// for one integrate-and-fire engine.
interface nurn_integrate_fire_if #(
  parameter int NUM_AXONS          = 256,
  parameter int DSIZE              = 16,
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AXON_CNT_BIT_WIDTH = 8
);
  // start_i is accepted only in a cycle where busy_o=0. busy_o stays high from the
  // cycle after acceptance through the done_o pulse. spike_o/spikeNurn_o qualify with done_o.
  logic                                        start_i;
  logic [NURN_CNT_BIT_WIDTH-1:0]               nurnIdx_i;
  logic [NUM_AXONS-1:0]                        axonSpk_i;
  logic                                        busy_o;
  logic                                        done_o;
  logic                                        spike_o;
  logic [NURN_CNT_BIT_WIDTH-1:0]               spikeNurn_o;
  logic [NURN_CNT_BIT_WIDTH+1:0]               Addr_StatRd_A_o;
  logic                                        rdEn_StatRd_A_o;
  logic [DSIZE-1:0]                            data_StatRd_A_i;
  logic [NURN_CNT_BIT_WIDTH+1:0]               Addr_StatWr_B_o;
  logic                                        wrEn_StatWr_B_o;
  logic [DSIZE-1:0]                            data_StatWr_B_o;
  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_StatRd_E_o;
  logic                                        rdEn_StatRd_E_o;
  logic [DSIZE-1:0]                            data_StatRd_E_i;

  modport master (
    output start_i, nurnIdx_i, axonSpk_i, data_StatRd_A_i, data_StatRd_E_i,
    input  busy_o, done_o, spike_o, spikeNurn_o,
    input  Addr_StatRd_A_o, rdEn_StatRd_A_o, Addr_StatWr_B_o, wrEn_StatWr_B_o,
    input  data_StatWr_B_o, Addr_StatRd_E_o, rdEn_StatRd_E_o
  );

  modport slave (
    input  start_i, nurnIdx_i, axonSpk_i, data_StatRd_A_i, data_StatRd_E_i,
    output busy_o, done_o, spike_o, spikeNurn_o,
    output Addr_StatRd_A_o, rdEn_StatRd_A_o, Addr_StatWr_B_o, wrEn_StatWr_B_o,
    output data_StatWr_B_o, Addr_StatRd_E_o, rdEn_StatRd_E_o
  );
endinterface

// File: rtl/nurn_integrate_fire.sv
// Integrate-and-fire update of one neuron: read bias/pot/th, accumulate weights of
// spiking axons, saturate, compare to threshold, write back potential, report spike.
module nurn_integrate_fire #(
  parameter int NUM_NURNS          = 256,
  parameter int NUM_AXONS          = 256,
  parameter int DSIZE              = 16,
  parameter int NURN_CNT_BIT_WIDTH = $clog2(NUM_NURNS),
  parameter int AXON_CNT_BIT_WIDTH = $clog2(NUM_AXONS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  nurn_integrate_fire_if.slave bus,
  output logic [2:0]           state_dbg
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD_BIAS, S_RD_POT, S_RD_TH, S_ACC, S_DRAIN, S_WR, S_DONE
  } state_t;

  localparam int AW = DSIZE + AXON_CNT_BIT_WIDTH + 2;
  localparam int SW = AW + 2;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DSIZE+1){1'b0}}, {(DSIZE-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DSIZE+1){1'b1}}, {(DSIZE-1){1'b0}}};
  localparam logic [AXON_CNT_BIT_WIDTH-1:0] LAST_AXON = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);

  state_t                          state;
  logic [NURN_CNT_BIT_WIDTH-1:0]   nurn_q;
  logic [AXON_CNT_BIT_WIDTH-1:0]   axon_q;
  logic [AXON_CNT_BIT_WIDTH-1:0]   axon_nxt;
  logic signed [DSIZE-1:0]         bias_q, pot_q, th_q;
  logic signed [AW-1:0]            acc_q, acc_nxt;
  logic                            rd_e_q;
  logic                            fire_q;
  logic signed [SW-1:0]            sum;
  logic signed [DSIZE-1:0]         sat;
  logic                            fire;

  assign state_dbg = state;
  assign axon_nxt  = axon_q + 1'b1;

  // Weight data is only meaningful the cycle after an issued E read.
  always_comb begin
    acc_nxt = acc_q;
    if (rd_e_q)
      acc_nxt = acc_q + {{(AW-DSIZE){bus.data_StatRd_E_i[DSIZE-1]}}, bus.data_StatRd_E_i};
  end

  always_comb begin
    sum = {{(SW-DSIZE){pot_q[DSIZE-1]}}, pot_q}
        + {{(SW-DSIZE){bias_q[DSIZE-1]}}, bias_q}
        + {{(SW-AW){acc_nxt[AW-1]}}, acc_nxt};
    sat = sum[DSIZE-1:0];
    if (sum > SAT_MAX)      sat = {1'b0, {(DSIZE-1){1'b1}}};
    else if (sum < SAT_MIN) sat = {1'b1, {(DSIZE-1){1'b0}}};
    fire = (sat >= th_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= S_IDLE;
      nurn_q              <= '0;
      axon_q              <= '0;
      bias_q              <= '0;
      pot_q               <= '0;
      th_q                <= '0;
      acc_q               <= '0;
      rd_e_q              <= 1'b0;
      fire_q              <= 1'b0;
      bus.busy_o          <= 1'b0;
      bus.done_o          <= 1'b0;
      bus.spike_o         <= 1'b0;
      bus.spikeNurn_o     <= '0;
      bus.Addr_StatRd_A_o <= '0;
      bus.rdEn_StatRd_A_o <= 1'b0;
      bus.Addr_StatWr_B_o <= '0;
      bus.wrEn_StatWr_B_o <= 1'b0;
      bus.data_StatWr_B_o <= '0;
      bus.Addr_StatRd_E_o <= '0;
      bus.rdEn_StatRd_E_o <= 1'b0;
    end else begin
      rd_e_q <= bus.rdEn_StatRd_E_o;
      acc_q  <= acc_nxt;
      case (state)
        S_IDLE: if (bus.start_i) begin
          nurn_q              <= bus.nurnIdx_i;
          acc_q               <= '0;
          axon_q              <= '0;
          bus.busy_o          <= 1'b1;
          bus.rdEn_StatRd_A_o <= 1'b1;
          bus.Addr_StatRd_A_o <= {bus.nurnIdx_i, 2'b00};
          state               <= S_RD_BIAS;
        end
        S_RD_BIAS: begin
          bus.Addr_StatRd_A_o <= {nurn_q, 2'b01};
          state               <= S_RD_POT;
        end
        S_RD_POT: begin
          bias_q              <= bus.data_StatRd_A_i;
          bus.Addr_StatRd_A_o <= {nurn_q, 2'b10};
          state               <= S_RD_TH;
        end
        S_RD_TH: begin
          pot_q               <= bus.data_StatRd_A_i;
          bus.rdEn_StatRd_A_o <= 1'b0;
          bus.rdEn_StatRd_E_o <= bus.axonSpk_i[0];
          bus.Addr_StatRd_E_o <= {nurn_q, {AXON_CNT_BIT_WIDTH{1'b0}}};
          state               <= S_ACC;
        end
        S_ACC: begin
          // Threshold read issued in RD_TH lands in the first ACC cycle.
          if (axon_q == '0) th_q <= bus.data_StatRd_A_i;
          if (axon_q == LAST_AXON) begin
            axon_q              <= '0;
            bus.rdEn_StatRd_E_o <= 1'b0;
            state               <= S_DRAIN;
          end else begin
            axon_q              <= axon_nxt;
            bus.rdEn_StatRd_E_o <= bus.axonSpk_i[axon_nxt];
            bus.Addr_StatRd_E_o <= {nurn_q, axon_nxt};
          end
        end
        S_DRAIN: begin
          fire_q              <= fire;
          bus.wrEn_StatWr_B_o <= 1'b1;
          bus.Addr_StatWr_B_o <= {nurn_q, 2'b01};
          bus.data_StatWr_B_o <= fire ? '0 : sat;
          state               <= S_WR;
        end
        S_WR: begin
          bus.wrEn_StatWr_B_o <= 1'b0;
          bus.done_o          <= 1'b1;
          bus.spike_o         <= fire_q;
          bus.spikeNurn_o     <= nurn_q;
          state               <= S_DONE;
        end
        S_DONE: begin
          bus.done_o  <= 1'b0;
          bus.spike_o <= 1'b0;
          bus.busy_o  <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nurn_integrate_fire.sv
// Bench for nurn_integrate_fire: status/weight memory model, bus monitor and an
// arithmetic reference model of the integrate-and-fire rule.
module tb_nurn_integrate_fire;
  localparam int NN = 4;
  localparam int NA = 4;
  localparam int DS = 16;
  localparam int NB = 2;
  localparam int AB = 2;
  localparam int LAT = 6 + NA;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nurn_integrate_fire_if #(.NUM_AXONS(NA), .DSIZE(DS), .NURN_CNT_BIT_WIDTH(NB),
                           .AXON_CNT_BIT_WIDTH(AB)) bus ();

  nurn_integrate_fire #(.NUM_NURNS(NN), .NUM_AXONS(NA), .DSIZE(DS)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic signed [DS-1:0] bias_m [NN];
  logic signed [DS-1:0] pot_m  [NN];
  logic signed [DS-1:0] th_m   [NN];
  logic signed [DS-1:0] w_m    [NN][NA];

  function automatic logic [DS-1:0] a_word(input logic [NB+1:0] a);
    case (a[1:0])
      2'b00:   return bias_m[a[NB+1:2]];
      2'b01:   return pot_m[a[NB+1:2]];
      2'b10:   return th_m[a[NB+1:2]];
      default: return DS'($urandom);
    endcase
  endfunction

  // Memory: data one cycle after the read; random junk when no read was issued.
  always @(posedge clk) begin
    if (bus.rdEn_StatRd_A_o) bus.data_StatRd_A_i <= a_word(bus.Addr_StatRd_A_o);
    else                     bus.data_StatRd_A_i <= DS'($urandom);
    if (bus.rdEn_StatRd_E_o)
      bus.data_StatRd_E_i <= w_m[bus.Addr_StatRd_E_o[NB+AB-1:AB]][bus.Addr_StatRd_E_o[AB-1:0]];
    else
      bus.data_StatRd_E_i <= DS'($urandom);
  end

  // Monitor
  logic [NB+1+DS:0]   wr_q [$];
  logic [NB+AB-1:0]   e_q [$];
  logic [NB+AB-1:0]   exp_q [$];
  bit                 done_seen;
  int                 done_cnt = 0;
  int                 done_lat;
  logic               done_spk, done_busy;
  logic [NB-1:0]      done_nurn;
  int                 start_cyc;

  always @(negedge clk) begin
    if (bus.wrEn_StatWr_B_o) wr_q.push_back({bus.Addr_StatWr_B_o, bus.data_StatWr_B_o});
    if (bus.rdEn_StatRd_E_o) e_q.push_back(bus.Addr_StatRd_E_o);
    if (bus.done_o) begin
      done_seen = 1'b1;
      done_cnt++;
      done_lat  = cyc - start_cyc;
      done_spk  = bus.spike_o;
      done_busy = bus.busy_o;
      done_nurn = bus.spikeNurn_o;
    end
  end

  // Reference: pot + bias + sum of spiking weights, saturated, equality fires.
  task automatic ref_calc(input int n, input logic [NA-1:0] spk,
                          output logic [DS-1:0] d, output logic s);
    longint sum;
    sum = longint'(pot_m[n]) + longint'(bias_m[n]);
    exp_q.delete();
    for (int a = 0; a < NA; a++)
      if (spk[a]) begin
        sum += longint'(w_m[n][a]);
        exp_q.push_back(NB'(n) * NA + a);
      end
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    s = (sum >= longint'(th_m[n]));
    d = s ? '0 : sum[DS-1:0];
  endtask

  // Called half a tick past a rising edge; returns likewise, in the cycle after done.
  task automatic do_update(input int n, input logic [NA-1:0] spk, input int extra_start,
                           input int rst_at, input int max_cyc);
    wr_q.delete();
    e_q.delete();
    done_seen       = 1'b0;
    bus.start_i     = 1'b1;
    bus.nurnIdx_i   = NB'(n);
    bus.axonSpk_i   = spk;
    start_cyc       = cyc;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk); #1;
      bus.start_i = (k == extra_start);
      if (k == extra_start) bus.nurnIdx_i = NB'(n + 1);
      rst = (k == rst_at);
      if (done_seen) break;
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_op(input string tag, input int n, input logic [NA-1:0] spk,
                         input int extra_start);
    logic [DS-1:0] ed;
    logic          es;
    ref_calc(n, spk, ed, es);
    do_update(n, spk, extra_start, 0, 40);
    n_cmp++; if (done_seen !== 1'b1) begin n_err++; $display("FAIL %s_timeout done=%0b exp 1", tag, done_seen); end
    n_cmp++; if (done_lat !== LAT) begin n_err++; $display("FAIL %s_latency got %0d exp %0d", tag, done_lat, LAT); end
    n_cmp++; if (done_nurn !== NB'(n)) begin n_err++; $display("FAIL %s_nurn got %0d exp %0d", tag, done_nurn, n); end
    n_cmp++; if (done_spk !== es) begin n_err++; $display("FAIL %s_spike got %0b exp %0b", tag, done_spk, es); end
    n_cmp++; if (done_busy !== 1'b1) begin n_err++; $display("FAIL %s_busy_at_done got %0b exp 1", tag, done_busy); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL %s_busy_after got %0b exp 0", tag, bus.busy_o); end
    n_cmp++;
    if (wr_q.size() !== 1) begin
      n_err++; $display("FAIL %s_wr_count got %0d exp 1", tag, wr_q.size());
    end else begin
      n_cmp++;
      if (wr_q[0] !== {NB'(n), 2'b01, ed}) begin
        n_err++; $display("FAIL %s_wr got %h exp %h", tag, wr_q[0], {NB'(n), 2'b01, ed});
      end
    end
    n_cmp++;
    if (e_q.size() !== exp_q.size()) begin
      n_err++; $display("FAIL %s_e_reads got %0d exp %0d", tag, e_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < e_q.size(); i++) begin
        n_cmp++;
        if (e_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL %s_e_addr%0d got %h exp %h", tag, i, e_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic fill_random();
    for (int n = 0; n < NN; n++) begin
      bias_m[n] = DS'($urandom_range(0, 400)) - 16'sd200;
      pot_m[n]  = DS'($urandom);
      th_m[n]   = DS'($urandom);
      for (int a = 0; a < NA; a++) w_m[n][a] = DS'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0; bus.nurnIdx_i = '0; bus.axonSpk_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({bus.busy_o, bus.done_o, bus.spike_o} !== 3'b000) begin n_err++; $display("FAIL reset_status got %b exp 000", {bus.busy_o, bus.done_o, bus.spike_o}); end
    n_cmp++; if ({bus.rdEn_StatRd_A_o, bus.rdEn_StatRd_E_o, bus.wrEn_StatWr_B_o} !== 3'b000) begin n_err++; $display("FAIL reset_enables got %b exp 000", {bus.rdEn_StatRd_A_o, bus.rdEn_StatRd_E_o, bus.wrEn_StatWr_B_o}); end
    n_cmp++; if ({bus.Addr_StatRd_A_o, bus.Addr_StatWr_B_o, bus.Addr_StatRd_E_o, bus.spikeNurn_o} !== '0) begin n_err++; $display("FAIL reset_addr got nonzero exp 0"); end
    n_cmp++; if (bus.data_StatWr_B_o !== '0) begin n_err++; $display("FAIL reset_data got %h exp 0", bus.data_StatWr_B_o); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_t1_t2();
    fill_random();
    bias_m[2] = 16'sd1; pot_m[2] = 16'sd10; th_m[2] = 16'sd100;
    w_m[2][0] = 16'sd5; w_m[2][1] = 16'sd6; w_m[2][2] = 16'sd7; w_m[2][3] = 16'sd8;
    test_op("t1", 2, 4'b1111, 0);
    n_cmp++; if (wr_q.size() > 0 && wr_q[0][DS-1:0] !== 16'd37) begin n_err++; $display("FAIL t1_sum got %0d exp 37", wr_q[0][DS-1:0]); end
    th_m[2] = 16'sd37;
    test_op("t2", 2, 4'b1111, 0);
    n_cmp++; if (done_spk !== 1'b1) begin n_err++; $display("FAIL t2_equal_fires got %0b exp 1", done_spk); end
  endtask

  task automatic test_no_spikes();
    bias_m[1] = -16'sd3; pot_m[1] = 16'sd2; th_m[1] = 16'sd5;
    test_op("t3", 1, 4'b0000, 0);
    n_cmp++; if (wr_q.size() > 0 && wr_q[0][DS-1:0] !== 16'hFFFF) begin n_err++; $display("FAIL t3_data got %h exp ffff", wr_q[0][DS-1:0]); end
  endtask

  task automatic test_saturation();
    bias_m[3] = 16'sd0; pot_m[3] = 16'sh7FF0; th_m[3] = 16'sh7FFF;
    for (int a = 0; a < NA; a++) w_m[3][a] = 16'sh7FFF;
    test_op("t4_pos", 3, 4'b1111, 0);
    n_cmp++; if (done_spk !== 1'b1) begin n_err++; $display("FAIL t4_pos_fire got %0b exp 1", done_spk); end
    bias_m[0] = -16'sd1; pot_m[0] = 16'sh8000; th_m[0] = 16'sd0;
    for (int a = 0; a < NA; a++) w_m[0][a] = 16'sh8000;
    test_op("t4_neg", 0, 4'b1111, 0);
    n_cmp++; if (wr_q.size() > 0 && wr_q[0][DS-1:0] !== 16'h8000) begin n_err++; $display("FAIL t4_neg_data got %h exp 8000", wr_q[0][DS-1:0]); end
  endtask

  task automatic test_sparse_ignore_start();
    int cnt0;
    int wr0;
    fill_random();
    test_op("t5", 1, 4'b0101, 3);
    cnt0 = done_cnt;
    wr0  = wr_q.size();
    repeat (12) begin @(posedge clk); #1; end
    n_cmp++; if (done_cnt !== cnt0) begin n_err++; $display("FAIL t5_queued_start got %0d dones exp %0d", done_cnt, cnt0); end
    n_cmp++; if (wr_q.size() !== wr0) begin n_err++; $display("FAIL t5_extra_write got %0d exp %0d", wr_q.size(), wr0); end
  endtask

  task automatic test_mid_reset();
    fill_random();
    do_update(2, 4'b1111, 0, 6, 7);
    n_cmp++; if ({bus.busy_o, bus.rdEn_StatRd_A_o, bus.rdEn_StatRd_E_o, bus.wrEn_StatWr_B_o} !== 4'b0000) begin n_err++; $display("FAIL t6_after_reset got %b exp 0000", {bus.busy_o, bus.rdEn_StatRd_A_o, bus.rdEn_StatRd_E_o, bus.wrEn_StatWr_B_o}); end
    repeat (15) begin @(posedge clk); #1; end
    n_cmp++; if (wr_q.size() !== 0) begin n_err++; $display("FAIL t6_write got %0d exp 0", wr_q.size()); end
    n_cmp++; if (done_seen !== 1'b0) begin n_err++; $display("FAIL t6_done got %0b exp 0", done_seen); end
    test_op("t6_next", 2, 4'b1011, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      fill_random();
      if ($urandom_range(0, 3) == 0) th_m[0] = 16'sh8000;
      test_op($sformatf("rnd%0d", i), $urandom_range(0, NN - 1), NA'($urandom), 0);
    end
  endtask

  // Each test returns right after done, so consecutive updates start back to back.
  task automatic test_back_to_back();
    fill_random();
    test_op("b2b_a", 0, 4'b1001, 0);
    test_op("b2b_b", 3, 4'b0110, 0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.nurnIdx_i = '0;
    bus.axonSpk_i = '0;
    fill_random();
    test_reset();
    test_t1_t2();
    test_no_spikes();
    test_saturation();
    test_sparse_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
